// File: rtl/imem_refill_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_refill_responder
// Purpose  : Memory-side responder for instruction-cache refills. Owns the
//            instruction storage array, accepts one single-word request at a
//            time over a ready/valid channel, and returns the word after a
//            fixed LATENCY. A loader port writes the array for program
//            download.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            req_valid/ready - request handshake, req_addr = byte address
//            resp_valid/ready- response handshake
//            resp_data       - instruction word (NOP_WORD on error)
//            resp_addr       - echo of accepted request address
//            resp_err        - misaligned or out-of-range request
//            wr_en/addr/data - loader write port (bad addresses dropped)
//            busy            - transaction in progress
// Revision : 1.0 - initial release
// ============================================================================
module imem_refill_responder #(
    parameter int          DEPTH    = 64,           // >= 2 words
    parameter int          LATENCY  = 3,            // 1..15
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [31:0] resp_addr,
    output logic        resp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy
);

    localparam int         c_IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_resp_data;
    logic [31:0] r_resp_addr;
    logic        r_resp_err;

    // Storage array; intentionally not reset so a loaded program survives.
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_sample;
    logic        w_rd_err;
    logic        w_wr_ok;

    assign w_accept = req_valid && (r_state == c_IDLE);
    // Last WAIT cycle: the coming edge reads the array (before any write on
    // that same edge lands, since both are non-blocking updates).
    assign w_sample = (r_state == c_WAIT) && (r_cnt == 4'd0);

    assign w_rd_err = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH));
    assign w_wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) &&
                      (wr_addr[31:2] < 30'(DEPTH));

    // Outputs decoded from registered state only.
    assign req_ready  = (r_state == c_IDLE);
    assign busy       = (r_state != c_IDLE);
    assign resp_valid = (r_state == c_RESP);
    assign resp_data  = r_resp_data;
    assign resp_addr  = r_resp_addr;
    assign resp_err   = r_resp_err;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (req_valid)      w_state_nxt = c_WAIT;
            c_WAIT:  if (r_cnt == 4'd0)  w_state_nxt = c_RESP;
            c_RESP:  if (resp_ready)     w_state_nxt = c_IDLE;
            default:                     w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, latency counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_resp_data <= 32'd0;
            r_resp_addr <= 32'd0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
                r_cnt  <= c_CNT_INIT;
            end else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_sample) begin
                r_resp_addr <= r_addr;
                r_resp_err  <= w_rd_err;
                r_resp_data <= w_rd_err ? NOP_WORD : r_mem[r_addr[c_IDX_W+1:2]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Loader write port, active in every state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr[c_IDX_W+1:2]] <= wr_data;
        end
    end

endmodule
`default_nettype wire
